axi_wr_arbiter: RTL and testbench
=================================

# axi_wr_arbiter

AXI3 write-path arbiter sharing one slave-side AXI write port (AW, W, B channels) between `NUM_M` masters. It sits between the master agents/DUT initiators and the single slave port driven by the responder clocking block.
- AW requests are granted round-robin.
- W beats follow the order in which AW grants were given.
- The master index is prepended to AWID/WID.
- B responses are routed back by the top bits of BID.

The read channels are out of scope and are wired straight through elsewhere.

## Interface
- `NUM_M`, default 2: number of masters, 2..4.
- `M_ID_W`, default 3: master-side ID width. Slave-side ID width is `S_ID_W = M_ID_W + MI_W`, where `MI_W = $clog2(NUM_M)`. With the defaults, `S_ID_W = 4`.
- `ADDR_W`, default `ADDR_BUS_WIDTH`: address width.
- `DATA_W`, default `DATA_BUS_WIDTH`: data width. Strobe width is `DATA_W/8`.
- `ORD_DEPTH`, default 4: depth of the write-order FIFO (power of 2).

Ports. `m_*` signals are packed `NUM_M` × field, with master *i* at slice *i*.
- `aclk`, in, 1: clock; all logic on the rising edge.
- `arst`, in, 1: asynchronous, active-low reset.
- `m_awid`, in, NUM_M·M_ID_W: master write-address IDs.
- `m_awaddr`, `m_awlen`(4), `m_awsize`(3), `m_awburst`(2), `m_awlock`(2), `m_awcache`(4), `m_awprot`(3), in, NUM_M × field: master AW payload.
- `m_awvalid`, in, NUM_M; `m_awready`, out, NUM_M: master AW handshake.
- `m_wid`, in, NUM_M·M_ID_W; `m_wdata`, `m_wstrb`, `m_wlast`, in, NUM_M × field: master W payload.
- `m_wvalid`, in, NUM_M; `m_wready`, out, NUM_M: master W handshake.
- `m_bid`, out, NUM_M·M_ID_W; `m_bresp`, out, NUM_M·2; `m_bvalid`, out, NUM_M; `m_bready`, in, NUM_M: master B channel.
- `s_aw*`, out, single copy of each AW field; `s_awid` is S_ID_W wide; `s_awvalid` out; `s_awready` in.
- `s_wid`(S_ID_W), `s_wdata`, `s_wstrb`, `s_wlast`, `s_wvalid`, out; `s_wready`, in.
- `s_bid`(S_ID_W), `s_bresp`(2), `s_bvalid`, in; `s_bready`, out.

## Operation
- **AW FSM states:** `IDLE`, `GRANT`.
  - `IDLE`: if any `m_awvalid` is set and the order FIFO is not full, pick the first requester at or after `rr_ptr` (modulo `NUM_M`), register `gnt`, and go to `GRANT`.
  - `GRANT`:
    - `s_awvalid = m_awvalid[gnt]`.
    - `s_awid = {gnt, m_awid[gnt]}`; other AW fields come from `m_aw*[gnt]`.
    - `m_awready[gnt] = s_awready`; all other `m_awready` are 0.
    - On the `s_awvalid & s_awready` handshake: push `gnt` into the order FIFO, set `rr_ptr = gnt+1` (wraps at `NUM_M`), and go to `IDLE`.
- **W mux:** when the FIFO is non-empty, `h` = FIFO head.
  - `s_wvalid = m_wvalid[h]`, `s_w* = m_w*[h]`, `s_wid = {h, m_wid[h]}`.
  - `m_wready[h] = s_wready`.
  - Pop the FIFO on a `s_wvalid & s_wready & s_wlast` handshake.
  - When the FIFO is empty: `s_wvalid = 0` and all `m_wready = 0`.
- **B demux:** `k = s_bid[S_ID_W-1 -: MI_W]`.
  - `m_bvalid[k] = s_bvalid`, `m_bid[k] = s_bid[M_ID_W-1:0]`, `m_bresp[k] = s_bresp`.
  - `s_bready = m_bready[k]`.
  - A `k` ≥ `NUM_M` is accepted and dropped: `s_bready = 1`.
- **Beat counting:** the W path does not count beats; `wlast` alone terminates a burst.

## Timing
- **Reset values:** state = `IDLE`, `gnt` = 0, `rr_ptr` = 0, FIFO empty. All valid and ready outputs = 0.
- **Reset mid-burst:** reset mid-burst discards everything in flight, including FIFO contents.
- **AW latency:** a request in cycle *t* gives `s_awvalid` at *t+1*. Maximum AW throughput is one handshake per 2 cycles.
- **AW stability:** the AW payload is stable while in `GRANT`, because AXI requires `awvalid` to stay asserted until handshake.
- **W path:** combinational from the FIFO head; zero added latency, so full beat rate is possible.
- **FIFO full:** AW is blocked in `IDLE` until a pop.
- **Simultaneous push and pop:** when the FIFO is full, a push and pop in the same cycle are not possible, because the push is blocked in `IDLE` by the full condition.
- **W before AW:** W beats for a master whose AW is not yet granted are held (`m_wready` = 0).
- **B path:** purely combinational.

## Configuration
- **`AXI_ARB_LOCK_EN` defined:**
  - An AW handshake with `awlock == 2'b10` (locked) from master *m* sets `lock_act` and `lock_m = m`.
  - While `lock_act`, `IDLE` considers only master `lock_m`.
  - The next completed AW from `lock_m` with `awlock != 2'b10` clears `lock_act`.
  - `lock_act` resets to 0.
- **Not defined:** `awlock` is passed through unchanged and has no effect on arbitration.

## Test plan
- Single master 0, AW `awid=3`, `awlen=3`, W 4 beats → `s_awid=4'b0011`, 4 W beats with `s_wid=4'b0011`, `wlast` on beat 4. `s_bid=4'b0011`, `bresp=0` → `m_bvalid[0]=1`, `m_bid=3`.
- Both masters assert `awvalid` continuously from reset → grants in order 0, 1, 0, 1. `s_awvalid` high in alternate cycles.
- Master 1 W beats presented before master 0, with AW order 0 then 1 → `m_wready[1]=0` until master 0's `wlast` handshake.
- Five AWs issued with `s_wready=0` → 4 accepted, the 5th held (`s_awvalid=0`) until the first `wlast` pops the FIFO.
- `s_bid=4'b1010` with `m_bready[1]=0` → `s_bready=0`; `m_bvalid[1]=1`, `m_bid[1]=3'b010`.
- With `AXI_ARB_LOCK_EN`: master 0 locked AW, then master 1 requests → master 1 is not granted until master 0 issues an unlocked AW.
- Assert `arst` mid-burst → all valid and ready outputs are 0 in the same cycle; the FIFO is empty after release.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// AXI3 write-path arbiter: round-robin AW grant, W beats follow AW grant order, B routed by BID top bits.
// Define AXI_ARB_LOCK_EN to honour locked (awlock == 2'b10) sequences during arbitration.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module axi_wr_arbiter #(
   parameter int NUM_M     = 2,
   parameter int M_ID_W    = 3,
   parameter int ADDR_W    = `ADDR_BUS_WIDTH,
   parameter int DATA_W    = `DATA_BUS_WIDTH,
   parameter int ORD_DEPTH = 4,
   localparam int MI_W     = $clog2(NUM_M),
   localparam int S_ID_W   = M_ID_W + MI_W,
   localparam int STRB_W   = DATA_W / 8
) (
   input  logic                       aclk,
   input  logic                       arst,
   // master AW
   input  logic [NUM_M*M_ID_W-1:0]    m_awid,
   input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
   input  logic [NUM_M*4-1:0]         m_awlen,
   input  logic [NUM_M*3-1:0]         m_awsize,
   input  logic [NUM_M*2-1:0]         m_awburst,
   input  logic [NUM_M*2-1:0]         m_awlock,
   input  logic [NUM_M*4-1:0]         m_awcache,
   input  logic [NUM_M*3-1:0]         m_awprot,
   input  logic [NUM_M-1:0]           m_awvalid,
   output logic [NUM_M-1:0]           m_awready,
   // master W
   input  logic [NUM_M*M_ID_W-1:0]    m_wid,
   input  logic [NUM_M*DATA_W-1:0]    m_wdata,
   input  logic [NUM_M*STRB_W-1:0]    m_wstrb,
   input  logic [NUM_M-1:0]           m_wlast,
   input  logic [NUM_M-1:0]           m_wvalid,
   output logic [NUM_M-1:0]           m_wready,
   // master B
   output logic [NUM_M*M_ID_W-1:0]    m_bid,
   output logic [NUM_M*2-1:0]         m_bresp,
   output logic [NUM_M-1:0]           m_bvalid,
   input  logic [NUM_M-1:0]           m_bready,
   // slave AW
   output logic [S_ID_W-1:0]          s_awid,
   output logic [ADDR_W-1:0]          s_awaddr,
   output logic [3:0]                 s_awlen,
   output logic [2:0]                 s_awsize,
   output logic [1:0]                 s_awburst,
   output logic [1:0]                 s_awlock,
   output logic [3:0]                 s_awcache,
   output logic [2:0]                 s_awprot,
   output logic                       s_awvalid,
   input  logic                       s_awready,
   // slave W
   output logic [S_ID_W-1:0]          s_wid,
   output logic [DATA_W-1:0]          s_wdata,
   output logic [STRB_W-1:0]          s_wstrb,
   output logic                       s_wlast,
   output logic                       s_wvalid,
   input  logic                       s_wready,
   // slave B
   input  logic [S_ID_W-1:0]          s_bid,
   input  logic [1:0]                 s_bresp,
   input  logic                       s_bvalid,
   output logic                       s_bready
);

   localparam int PTR_W = $clog2(ORD_DEPTH);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q;
   logic [MI_W-1:0]   gnt_q;
   logic [MI_W-1:0]   rr_ptr_q;

   logic [MI_W-1:0]   ord_mem_q [ORD_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W:0]    cnt_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [MI_W-1:0]   head;

   logic [NUM_M-1:0]  elig;
   logic              pick_found;
   logic [MI_W-1:0]   pick_idx;
   logic [MI_W-1:0]   cand;
   logic              aw_hs;
   logic [MI_W-1:0]   b_idx;

   // ---------------- eligibility (optionally restricted by a locked sequence)
`ifdef AXI_ARB_LOCK_EN
   logic              lock_act_q;
   logic [MI_W-1:0]   lock_m_q;

   always_comb begin
      elig = '0;
      if (lock_act_q)
         elig[lock_m_q] = m_awvalid[lock_m_q];
      else
         elig = m_awvalid;
   end

   always_ff @(posedge aclk or negedge arst) begin
      if (!arst) begin
         lock_act_q <= 1'b0;
         lock_m_q   <= '0;
      end else if (aw_hs) begin
         if (s_awlock == 2'b10) begin
            lock_act_q <= 1'b1;
            lock_m_q   <= gnt_q;
         end else if (lock_act_q && (gnt_q == lock_m_q)) begin
            lock_act_q <= 1'b0;
         end
      end
   end
`else
   assign elig = m_awvalid;
`endif

   // Descending scan so the candidate closest to rr_ptr is the one kept.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = NUM_M - 1; i >= 0; i--) begin
         if (int'(rr_ptr_q) + i >= NUM_M)
            cand = MI_W'(int'(rr_ptr_q) + i - NUM_M);
         else
            cand = MI_W'(int'(rr_ptr_q) + i);
         if (elig[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // ---------------- AW FSM
   assign s_awvalid = (state_q == GRANT) & m_awvalid[gnt_q];
   assign aw_hs     = s_awvalid & s_awready;

   always_ff @(posedge aclk or negedge arst) begin
      if (!arst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found && !fifo_full) begin
                  gnt_q   <= pick_idx;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (aw_hs) begin
                  rr_ptr_q <= (gnt_q == MI_W'(NUM_M - 1)) ? '0 : gnt_q + 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_awid    = {gnt_q, m_awid[gnt_q*M_ID_W +: M_ID_W]};
   assign s_awaddr  = m_awaddr[gnt_q*ADDR_W +: ADDR_W];
   assign s_awlen   = m_awlen[gnt_q*4 +: 4];
   assign s_awsize  = m_awsize[gnt_q*3 +: 3];
   assign s_awburst = m_awburst[gnt_q*2 +: 2];
   assign s_awlock  = m_awlock[gnt_q*2 +: 2];
   assign s_awcache = m_awcache[gnt_q*4 +: 4];
   assign s_awprot  = m_awprot[gnt_q*3 +: 3];

   always_comb begin
      m_awready = '0;
      if (state_q == GRANT)
         m_awready[gnt_q] = s_awready;
   end

   // ---------------- write-order FIFO (grant index per accepted AW)
   assign push       = aw_hs;
   assign pop        = s_wvalid & s_wready & s_wlast;
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == (PTR_W + 1)'(ORD_DEPTH));
   assign head       = ord_mem_q[rd_ptr_q];

   always_ff @(posedge aclk) begin
      if (push)
         ord_mem_q[wr_ptr_q] <= gnt_q;
   end

   always_ff @(posedge aclk or negedge arst) begin
      if (!arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // ---------------- W mux from FIFO head
   assign s_wvalid = !fifo_empty & m_wvalid[head];
   assign s_wid    = {head, m_wid[head*M_ID_W +: M_ID_W]};
   assign s_wdata  = m_wdata[head*DATA_W +: DATA_W];
   assign s_wstrb  = m_wstrb[head*STRB_W +: STRB_W];
   assign s_wlast  = m_wlast[head];

   always_comb begin
      m_wready = '0;
      if (!fifo_empty)
         m_wready[head] = s_wready;
   end

   // ---------------- B demux; responses for a nonexistent master are sunk
   assign b_idx = s_bid[S_ID_W-1 -: MI_W];

   always_comb begin
      m_bvalid = '0;
      m_bid    = '0;
      m_bresp  = '0;
      s_bready = 1'b1;
      if (int'(b_idx) < NUM_M) begin
         m_bvalid[b_idx]                  = s_bvalid;
         m_bid[b_idx*M_ID_W +: M_ID_W]    = s_bid[M_ID_W-1:0];
         m_bresp[b_idx*2 +: 2]            = s_bresp;
         s_bready                         = m_bready[b_idx];
      end
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with NUM_M=2, M_ID_W=3, 32-bit address/data, ORD_DEPTH=4.
module tb_axi_wr_arbiter;

   logic        aclk = 1'b0;
   logic        arst = 1'b0;
   logic [5:0]  m_awid = '0;
   logic [63:0] m_awaddr = '0;
   logic [7:0]  m_awlen = '0;
   logic [5:0]  m_awsize = '0;
   logic [3:0]  m_awburst = '0;
   logic [3:0]  m_awlock = '0;
   logic [7:0]  m_awcache = '0;
   logic [5:0]  m_awprot = '0;
   logic [1:0]  m_awvalid = '0;
   logic [1:0]  m_awready;
   logic [5:0]  m_wid = '0;
   logic [63:0] m_wdata = '0;
   logic [7:0]  m_wstrb = '0;
   logic [1:0]  m_wlast = '0;
   logic [1:0]  m_wvalid = '0;
   logic [1:0]  m_wready;
   logic [5:0]  m_bid;
   logic [3:0]  m_bresp;
   logic [1:0]  m_bvalid;
   logic [1:0]  m_bready = '0;
   logic [3:0]  s_awid;
   logic [31:0] s_awaddr;
   logic [3:0]  s_awlen;
   logic [2:0]  s_awsize;
   logic [1:0]  s_awburst;
   logic [1:0]  s_awlock;
   logic [3:0]  s_awcache;
   logic [2:0]  s_awprot;
   logic        s_awvalid;
   logic        s_awready = 1'b0;
   logic [3:0]  s_wid;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wlast;
   logic        s_wvalid;
   logic        s_wready = 1'b0;
   logic [3:0]  s_bid = '0;
   logic [1:0]  s_bresp = '0;
   logic        s_bvalid = 1'b0;
   logic        s_bready;

   int n_total = 0;
   int n_bad   = 0;

   axi_wr_arbiter #(
      .NUM_M(2), .M_ID_W(3), .ADDR_W(32), .DATA_W(32), .ORD_DEPTH(4)
   ) dut (
      .aclk(aclk), .arst(arst),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      arst = 1'b0;
      tick();
      arst = 1'b1;
   endtask

   int ev [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
   int eid[11] = '{0, 1, 0, 10, 0, 1, 0, 10, 0, 0, 0};

   initial begin
      // reset state
      tick();
      tick();
      #1;
      chk("rst_s_awvalid", 64'(s_awvalid), 0);
      chk("rst_s_wvalid",  64'(s_wvalid), 0);
      chk("rst_m_awready", 64'(m_awready), 0);
      chk("rst_m_wready",  64'(m_wready), 0);
      chk("rst_m_bvalid",  64'(m_bvalid), 0);
      chk("rst_s_bready",  64'(s_bready), 0);
      arst = 1'b1;

      // single master 0 burst of 4
      tick();
      m_awid = 6'b000_011; m_awlen[3:0] = 4'd3; m_awaddr[31:0] = 32'h1000;
      m_awlock = 4'b0010; s_awready = 1'b1; m_awvalid = 2'b01;
      #1;
      chk("aw_latency", 64'(s_awvalid), 0);
      tick();
      #1;
      chk("aw1_valid",   64'(s_awvalid), 1);
      chk("aw1_id",      64'(s_awid), 64'h3);
      chk("aw1_len",     64'(s_awlen), 3);
      chk("aw1_addr",    64'(s_awaddr), 64'h1000);
      chk("aw1_lock",    64'(s_awlock), 2);
      chk("aw1_m_ready", 64'(m_awready), 1);
      tick();
      m_awvalid = 2'b00;
      for (int b = 0; b < 4; b++) begin
         m_wid = 6'b000_011; m_wdata[31:0] = 32'hA0 + 32'(b); m_wstrb[3:0] = 4'hF;
         m_wlast = (b == 3) ? 2'b01 : 2'b00; m_wvalid = 2'b01; s_wready = 1'b1;
         #1;
         chk("w1_valid",   64'(s_wvalid), 1);
         chk("w1_id",      64'(s_wid), 64'h3);
         chk("w1_data",    64'(s_wdata), 64'hA0 + 64'(b));
         chk("w1_last",    64'(s_wlast), (b == 3) ? 1 : 0);
         chk("w1_m_ready", 64'(m_wready), 1);
         tick();
      end
      #1;
      chk("w1_popped_valid", 64'(s_wvalid), 0);
      chk("w1_popped_ready", 64'(m_wready), 0);
      m_wvalid = 2'b00; m_wlast = 2'b00;
      s_bvalid = 1'b1; s_bid = 4'b0011; s_bresp = 2'b00; m_bready = 2'b01;
      #1;
      chk("b1_m_bvalid", 64'(m_bvalid), 1);
      chk("b1_m_bid",    64'(m_bid), 64'h3);
      chk("b1_s_bready", 64'(s_bready), 1);
      s_bresp = 2'b10;
      #1;
      chk("b1_m_bresp",  64'(m_bresp), 2);
      s_bvalid = 1'b0; m_bready = 2'b00;

      // both masters request continuously from reset; FIFO fills after four grants
      do_reset();
      m_awid = {3'd2, 3'd1}; m_awlock = 4'b0000; m_awvalid = 2'b11; s_awready = 1'b1; s_wready = 1'b0;
      for (int s = 0; s < 11; s++) begin
         #1;
         chk($sformatf("rr_valid_slot%0d", s), 64'(s_awvalid), 64'(ev[s]));
         if (ev[s] != 0)
            chk($sformatf("rr_id_slot%0d", s), 64'(s_awid), 64'(eid[s]));
         tick();
      end

      // W from master 1 waits behind master 0's burst
      m_wid = {3'd5, 3'd4}; m_wvalid = 2'b11; m_wlast = 2'b00;
      #1;
      chk("wo_stall_ready", 64'(m_wready), 0);
      chk("wo_head_valid",  64'(s_wvalid), 1);
      chk("wo_head_id",     64'(s_wid), 64'b0100);
      s_wready = 1'b1;
      #1;
      chk("wo_m0_ready", 64'(m_wready), 1);
      tick();
      #1;
      chk("wo_m1_held",  64'(m_wready), 1);
      chk("full_hold",   64'(s_awvalid), 0);
      m_wlast = 2'b01;
      #1;
      chk("wo_m0_last",  64'(s_wlast), 1);
      tick();
      m_wlast = 2'b00;
      #1;
      chk("wo_m1_ready", 64'(m_wready), 2);
      chk("wo_m1_id",    64'(s_wid), 64'b1101);
      chk("refill_idle", 64'(s_awvalid), 0);
      tick();
      #1;
      chk("refill_valid", 64'(s_awvalid), 1);
      chk("refill_id",    64'(s_awid), 64'b0001);
      chk("refill_ready", 64'(m_awready), 1);
      tick();
      #1;
      chk("refill_done",  64'(s_awvalid), 0);

      // B routed by top ID bit, backpressure from master 1
      s_bvalid = 1'b1; s_bid = 4'b1010; m_bready = 2'b01;
      #1;
      chk("b2_s_bready_lo", 64'(s_bready), 0);
      chk("b2_m_bvalid",    64'(m_bvalid), 2);
      chk("b2_m_bid",       64'(m_bid), 64'b010_000);
      m_bready = 2'b10;
      #1;
      chk("b2_s_bready_hi", 64'(s_bready), 1);
      s_bvalid = 1'b0; s_bid = '0; m_bready = 2'b00;

      // reset in the middle of a burst
      m_awvalid = 2'b00; m_wvalid = 2'b11; s_wready = 1'b1; m_wlast = 2'b00;
      #1;
      chk("mid_burst_valid", 64'(s_wvalid), 1);
      arst = 1'b0;
      #1;
      chk("arst_s_awvalid", 64'(s_awvalid), 0);
      chk("arst_s_wvalid",  64'(s_wvalid), 0);
      chk("arst_m_wready",  64'(m_wready), 0);
      chk("arst_m_awready", 64'(m_awready), 0);
      tick();
      arst = 1'b1;
      #1;
      chk("post_rst_wvalid", 64'(s_wvalid), 0);
      chk("post_rst_wready", 64'(m_wready), 0);
      tick();
      #1;
      chk("post_rst_wvalid2", 64'(s_wvalid), 0);
      m_wvalid = 2'b00;

`ifdef AXI_ARB_LOCK_EN
      // locked sequence from master 0 shuts out master 1
      do_reset();
      m_awid = {3'd6, 3'd2}; m_awlock = 4'b0010; m_awvalid = 2'b01; s_awready = 1'b1; s_wready = 1'b0;
      tick();
      #1;
      chk("lk_m0_valid", 64'(s_awvalid), 1);
      chk("lk_m0_id",    64'(s_awid), 64'b0010);
      tick();
      m_awvalid = 2'b10;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk($sformatf("lk_m1_blocked%0d", s), 64'(s_awvalid), 0);
         tick();
      end
      m_awvalid = 2'b11; m_awlock = 4'b0000;
      tick();
      #1;
      chk("lk_unlock_valid", 64'(s_awvalid), 1);
      chk("lk_unlock_id",    64'(s_awid), 64'b0010);
      tick();
      m_awvalid = 2'b10;
      tick();
      #1;
      chk("lk_m1_valid", 64'(s_awvalid), 1);
      chk("lk_m1_id",    64'(s_awid), 64'b1110);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
